// File: rtl/vc_ready_queue_if.sv
// Write, grant, credit and output-link signals shared between the per-VC ready queue
// and whatever drives it (selector, upstream link, downstream credit return).
interface vc_ready_queue_if #(
  parameter int N     = 2,
  parameter int WIDTH = 16
);
  localparam int VC_W = (N > 1) ? $clog2(N) : 1;

  logic             in_valid;
  logic [VC_W-1:0]  in_vc;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [N-1:0]     sel;
  logic             sel_en;
  logic [N-1:0]     credit_in;
  logic [N-1:0]     ready;
  logic [N-1:0]     ready_urgent;
  logic             out_valid;
  logic [VC_W-1:0]  out_vc;
  logic [WIDTH-1:0] out_data;
  logic             sel_err;

  modport master (
    output in_valid, in_vc, in_data, sel, sel_en, credit_in,
    input  in_ready, ready, ready_urgent, out_valid, out_vc, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_vc, in_data, sel, sel_en, credit_in,
    output in_ready, ready, ready_urgent, out_valid, out_vc, out_data, sel_err
  );
endinterface

// File: rtl/vc_ready_queue.sv
// Per-VC flit queues with downstream credit and head-of-line age tracking; feeds
// ready/urgent vectors to the selector and pops the granted VC onto a registered link.
module vc_ready_queue #(
  parameter int N          = 2,
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 16,
  parameter int CREDITS    = 4,
  parameter int URGENT_OCC = 3,
  parameter int AGE_LIMIT  = 15
) (
  input logic            clock,
  input logic            reset,
  vc_ready_queue_if.slave q
);
  localparam int VC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CR_W  = $clog2(CREDITS + 1);
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [WIDTH-1:0] mem    [N][DEPTH];
  logic [PTR_W-1:0] rd_ptr [N];
  logic [PTR_W-1:0] wr_ptr [N];
  logic [CNT_W-1:0] count  [N];
  logic [CR_W-1:0]  credit [N];
  logic [AGE_W-1:0] age    [N];

  logic [N-1:0]     ready_c;
  logic [N-1:0]     urgent_c;
  logic             in_ready_c;
  logic [N-1:0]     enq;
  logic [N-1:0]     deq;
  logic             grant_ok;
  logic [VC_W-1:0]  grant_vc;
  logic [WIDTH-1:0] head;

  // Everything here reads registered state only, so the selector loop stays acyclic.
  always_comb begin
    ready_c    = '0;
    urgent_c   = '0;
    in_ready_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      ready_c[i]  = (count[i] != '0) && (credit[i] != '0);
      urgent_c[i] = ready_c[i] && ((count[i] >= CNT_W'(URGENT_OCC)) ||
                                   (age[i] >= AGE_W'(AGE_LIMIT)));
      if (q.in_vc == VC_W'(i))
        in_ready_c = (count[i] != CNT_W'(DEPTH));
    end
  end

  always_comb begin
    enq      = '0;
    grant_vc = '0;
    head     = '0;
    grant_ok = q.sel_en && $onehot(q.sel) && ((q.sel & ready_c) != '0);
    for (int i = 0; i < N; i++) begin
      enq[i] = q.in_valid && in_ready_c && (q.in_vc == VC_W'(i));
      if (q.sel[i]) begin
        grant_vc = VC_W'(i);
        head     = mem[i][rd_ptr[i]];
      end
    end
    deq = grant_ok ? q.sel : '0;
  end

  assign q.ready        = ready_c;
  assign q.ready_urgent = urgent_c;
  assign q.in_ready     = in_ready_c;

  // Storage is not reset; occupancy is tracked entirely by the pointers and counts.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (!reset && enq[i])
        mem[i][wr_ptr[i]] <= q.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        credit[i] <= CR_W'(CREDITS);
        age[i]    <= '0;
      end
      q.out_valid <= 1'b0;
      q.out_vc    <= '0;
      q.out_data  <= '0;
      q.sel_err   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (enq[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (deq[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;

        if (enq[i] && !deq[i])
          count[i] <= count[i] + 1'b1;
        else if (!enq[i] && deq[i])
          count[i] <= count[i] - 1'b1;

        if (q.credit_in[i] && !deq[i]) begin
          if (credit[i] != CR_W'(CREDITS))
            credit[i] <= credit[i] + 1'b1;
        end else if (!q.credit_in[i] && deq[i]) begin
          credit[i] <= credit[i] - 1'b1;
        end

        // Age measures how long the current head has waited, independent of credit.
        if ((count[i] == '0) || deq[i])
          age[i] <= '0;
        else if (age[i] != AGE_W'(AGE_LIMIT))
          age[i] <= age[i] + 1'b1;
      end

      q.out_valid <= grant_ok;
      q.sel_err   <= q.sel_en && !grant_ok;
      if (grant_ok) begin
        q.out_vc   <= grant_vc;
        q.out_data <= head;
      end
    end
  end
endmodule

// File: tb/tb_vc_ready_queue.sv
// Directed bench for vc_ready_queue: stimulus pushes expected link/sel_err events into
// a scoreboard that a negedge monitor drains; readiness vectors are checked inline.
module tb_vc_ready_queue;
  localparam int N = 2;
  localparam int WIDTH = 16;

  typedef struct {
    bit          is_err;
    int          vc;
    logic [15:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  vc_ready_queue_if #(.N(N), .WIDTH(WIDTH)) vif ();

  vc_ready_queue #(
    .N(N), .DEPTH(4), .WIDTH(WIDTH), .CREDITS(4), .URGENT_OCC(3), .AGE_LIMIT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .q(vif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input int vc, input logic [15:0] data);
    vif.in_valid = 1'b1;
    vif.in_vc    = vc[0:0];
    vif.in_data  = data;
    step();
    vif.in_valid = 1'b0;
  endtask

  task automatic grant(input int vc, input logic [15:0] data);
    exp_t e;
    e.is_err = 1'b0; e.vc = vc; e.data = data;
    sb.push_back(e);
    vif.sel    = 2'b01 << vc;
    vif.sel_en = 1'b1;
    step();
    vif.sel    = '0;
    vif.sel_en = 1'b0;
  endtask

  task automatic bad_grant(input logic [1:0] s);
    exp_t e;
    e.is_err = 1'b1; e.vc = 0; e.data = '0;
    sb.push_back(e);
    vif.sel    = s;
    vif.sel_en = 1'b1;
    step();
    vif.sel    = '0;
    vif.sel_en = 1'b0;
  endtask

  task automatic credit(input logic [1:0] c);
    vif.credit_in = c;
    step();
    vif.credit_in = '0;
  endtask

  // Monitor: any link or error output must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && (vif.out_valid || vif.sel_err)) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", {vif.out_valid, vif.sel_err}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sel_err", vif.sel_err, e.is_err);
          chk("sb_out_valid", vif.out_valid, !e.is_err);
          if (!e.is_err) begin
            chk("sb_out_vc", vif.out_vc, e.vc);
            chk("sb_out_data", vif.out_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vif.in_valid = 1'b0; vif.in_vc = '0; vif.in_data = '0;
    vif.sel = '0; vif.sel_en = 1'b0; vif.credit_in = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    chk("rst_ready", vif.ready, 0);
    chk("rst_urgent", vif.ready_urgent, 0);
    chk("rst_in_ready", vif.in_ready, 1);
    chk("rst_out_valid", vif.out_valid, 0);
    chk("rst_out_vc", vif.out_vc, 0);
    chk("rst_out_data", vif.out_data, 0);
    chk("rst_sel_err", vif.sel_err, 0);

    // Basic enqueue then grant on VC1.
    enq(1, 16'hA5A5);
    chk("basic_ready", vif.ready, 2'b10);
    grant(1, 16'hA5A5);
    chk("basic_ready_after", vif.ready, 2'b00);

    // Fill VC0, urgency by occupancy, drop on full, drain in order.
    for (int k = 0; k < 4; k++) begin
      vif.in_vc = 1'b0;
      #1 chk("fill_in_ready", vif.in_ready, 1);
      enq(0, 16'h1000 + 16'(k));
      chk("fill_urgent0", vif.ready_urgent[0], (k >= 2) ? 1 : 0);
    end
    vif.in_vc = 1'b0;
    #1 chk("full_in_ready0", vif.in_ready, 0);
    vif.in_vc = 1'b1;
    #1 chk("full_in_ready1", vif.in_ready, 1);
    enq(0, 16'h1FFF);
    for (int k = 0; k < 4; k++) grant(0, 16'h1000 + 16'(k));
    chk("drained_ready", vif.ready, 2'b00);

    // Credits exhausted: occupancy alone is not ready.
    for (int k = 0; k < 3; k++) enq(0, 16'h2000 + 16'(k));
    chk("nocredit_ready", vif.ready[0], 0);
    chk("nocredit_urgent", vif.ready_urgent[0], 0);
    credit(2'b01);
    chk("credit_ret_ready", vif.ready[0], 1);
    vif.credit_in = 2'b01;
    grant(0, 16'h2000);
    vif.credit_in = '0;
    chk("credit_ret_deq_ready", vif.ready[0], 1);
    grant(0, 16'h2001);
    chk("credit_zero_again", vif.ready[0], 0);
    for (int k = 0; k < 3; k++) credit(2'b01);
    enq(0, 16'h2003);
    enq(0, 16'h2004);
    for (int k = 0; k < 3; k++) grant(0, 16'h2002 + 16'(k));
    chk("wrap_drained", vif.ready[0], 0);
    for (int k = 0; k < 4; k++) credit(2'b01);

    // Aging on VC1: spend its 3 remaining credits, then let one flit sit.
    for (int k = 0; k < 3; k++) enq(1, 16'h3000 + 16'(k));
    chk("occ_urgent1", vif.ready_urgent[1], 1);
    for (int k = 0; k < 3; k++) grant(1, 16'h3000 + 16'(k));
    enq(1, 16'h3100);
    for (int k = 0; k < 20; k++) step();
    chk("aged_not_ready", vif.ready[1], 0);
    credit(2'b10);
    chk("aged_urgent", vif.ready_urgent[1], 1);
    grant(1, 16'h3100);
    vif.credit_in = 2'b10;
    enq(1, 16'h3200);
    vif.credit_in = '0;
    chk("fresh_ready", vif.ready[1], 1);
    chk("fresh_not_urgent", vif.ready_urgent[1], 0);
    grant(1, 16'h3200);

    // Illegal grants are no-ops with sel_err.
    enq(0, 16'h4000);
    chk("pre_illegal_ready", vif.ready, 2'b01);
    bad_grant(2'b11);
    chk("illegal_multi_ready", vif.ready, 2'b01);
    bad_grant(2'b00);
    chk("illegal_zero_ready", vif.ready, 2'b01);
    bad_grant(2'b10);
    chk("illegal_empty_ready", vif.ready, 2'b01);
    vif.sel = 2'b10;
    step();
    vif.sel = '0;
    grant(0, 16'h4000);

    // Mid-operation reset: VC0 2 flits credit 1, VC1 2 flits credit 1.
    for (int k = 0; k < 4; k++) enq(0, 16'h5000 + 16'(k));
    grant(0, 16'h5000);
    grant(0, 16'h5001);
    enq(1, 16'h5100);
    enq(1, 16'h5101);
    credit(2'b10);
    chk("pre_reset_ready", vif.ready, 2'b11);
    step();
    reset = 1'b1;
    vif.sel = 2'b01; vif.sel_en = 1'b1;
    step();
    reset = 1'b0;
    vif.sel = '0; vif.sel_en = 1'b0;
    chk("post_reset_ready", vif.ready, 0);
    chk("post_reset_urgent", vif.ready_urgent, 0);
    chk("post_reset_out_valid", vif.out_valid, 0);
    vif.in_vc = 1'b0;
    #1 chk("post_reset_in_ready", vif.in_ready, 1);
    // Four back-to-back grants prove credits returned to the full allowance.
    for (int k = 0; k < 4; k++) enq(0, 16'h6000 + 16'(k));
    for (int k = 0; k < 4; k++) grant(0, 16'h6000 + 16'(k));
    enq(0, 16'h6100);
    chk("post_reset_credit_used", vif.ready[0], 0);

    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vc_ready_queue.md
# vc_ready_queue

Bank of N per-virtual-channel flit queues that sits directly upstream of the ready-selection stage. It buffers incoming flits per VC and tracks downstream credits and head-of-line age per VC. It drives the ready and ready_urgent vectors into the selector. It dequeues the one VC named by the selector's one-hot grant and presents that flit registered to the output link.

## Interface
- N, 2: number of VCs/queues (≥2)
- DEPTH, 4: entries per queue (power of two, ≥2)
- WIDTH, 16: flit width in bits
- CREDITS, 4: initial/maximum downstream credits per VC (≥1)
- URGENT_OCC, 3: occupancy at or above which a ready VC is urgent (1..DEPTH)
- AGE_LIMIT, 15: head wait cycles at or above which a ready VC is urgent (≥1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  flit offered on write port
- in_vc  in  VC_W  target queue; VC_W = max(1, clog2(N))
- in_data  in  WIDTH  flit payload
- in_ready  out  1  combinational; 1 iff queue in_vc not full
- sel  in  N  one-hot grant from selector
- sel_en  in  1  grant is valid this cycle (selector's sel_valid OR sel_valid_urgent)
- credit_in  in  N  per-VC credit return pulse, one credit per asserted bit per cycle
- ready  out  N  combinational; ready[i] = count[i]>0 AND credit[i]>0
- ready_urgent  out  N  combinational; ready[i] AND (count[i] ≥ URGENT_OCC OR age[i] ≥ AGE_LIMIT)
- out_valid  out  1  registered; flit dequeued last cycle
- out_vc  out  VC_W  registered VC of out_data
- out_data  out  WIDTH  registered flit
- sel_err  out  1  registered; illegal grant seen last cycle

## Operation
- Per queue i: circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally) and count[i] (0..DEPTH). Also credit[i] (0..CREDITS) and age[i] (0..AGE_LIMIT, saturating).
- Enqueue: in_valid AND in_ready writes in_data at wr_ptr[in_vc]; wr_ptr increments; count increments. in_valid with in_ready=0 is dropped, with no state change. in_vc ≥ N is treated as not ready.
- Legal grant: sel_en=1, sel exactly one-hot at index i, and ready[i]=1. It pops the head of queue i, decrements count[i] and credit[i], and loads out_data/out_vc with out_valid=1 next cycle.
- Illegal grant: sel_en=1 with sel zero, multi-hot, or naming a non-ready VC. This is a no-op on all queue state and gives sel_err=1 next cycle. sel_en=0 means sel is ignored.
- in_ready depends only on registered count. A full queue refuses enqueue even if it is dequeued the same cycle.
- Simultaneous enqueue and dequeue on the same non-full queue: count unchanged, both pointers advance.
- Credits: credit_in[i] increments credit[i], and a dequeue of i decrements it. Both in one cycle leave it unchanged. A return when credit[i]=CREDITS (with no dequeue) saturates and is ignored.
- Age: age[i] resets to 0 when queue i is empty or is dequeued this cycle. Otherwise it increments while count[i]>0, saturating at AGE_LIMIT. Age counts regardless of credit availability.

## Timing
- Reset (synchronous, dominates all inputs):
  - All pointers, counts and ages reset to 0.
  - credit[i] = CREDITS.
  - out_valid=0, out_vc=0, out_data=0, sel_err=0.
  - ready and ready_urgent are 0 and in_ready is 1 in the cycle after reset.
- Enqueue to ready: a flit written on edge t makes ready visible after edge t (if credit>0). A grant can follow in that same cycle.
- Grant to output: 1-cycle latency. sel is sampled on edge t, and out_* is valid after edge t for exactly one cycle unless another grant occurs.
- ready/urgent → selector → sel is a single combinational loop-free path; ready depends only on registered state.
- Reset asserted mid-operation discards all buffered flits and returned credits. out_valid is 0 the following cycle.
- Back-to-back grants to the same VC are permitted every cycle while ready.

## Test plan
- Reset then idle: all outputs 0 and in_ready=1. Enqueue 0xA5A5 to VC1 → ready=2'b10 next cycle. Grant sel=2'b10 → out_valid=1, out_vc=1, out_data=0xA5A5 one cycle later, and ready=0.
- Fill VC0 with 4 flits → in_ready=0 for in_vc=0. ready_urgent[0]=1 once count=3. Fifth write dropped. Drain with 4 grants → data in order, with the wrap-around verified on a second fill.
- Credit exhaustion: 4 dequeues on VC0 with no returns → ready[0]=0 despite count>0. One credit_in[0] pulse → ready[0]=1 next cycle. Simultaneous return plus dequeue leaves credit unchanged.
- Aging: one flit in VC1, credit held at 0 for 15 cycles → ready_urgent[1]=1 as soon as a credit returns. A grant clears age, and a new flit is not urgent.
- Illegal grants: sel=2'b11, sel=2'b00 and sel to an empty VC, each with sel_en=1 → sel_err=1 next cycle, no count or credit change, out_valid=0.
- Reset asserted with both queues holding 2 flits and credit 1 → next cycle all counts 0, credit=CREDITS, ready=0, out_valid=0.
